arb_block_lv2: RTL and testbench

ARB_BLOCK_LV2 -- requirements
Module: arb_block_lv2

---
 rtl/arb_block_lv2.sv | 177 +++++++++++++++++
 tb/tb_arb_block_lv2.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/arb_block_lv2.sv
`default_nettype none
// ============================================================================
// Module   : arb_block_lv2
// Brief    : Round-robin L2 access arbiter. It grants one core per transaction
//            and sequences IDLE -> ISSUE -> WAIT. Define ARB_TIMEOUT_EN to add
//            forced release of a stuck WAIT after TIMEOUT_CYC cycles.
// Revision : 1.0 - initial release
// ============================================================================
module arb_block_lv2 #(
    parameter int NUM_REQ     = 4,
    parameter int REQ_ID_WID  = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_proc,
    input  logic                  l2_done,
    output logic [NUM_REQ-1:0]    gnt_proc,
    output logic [REQ_ID_WID-1:0] gnt_id,
    output logic                  l2_start,
    output logic                  busy,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [NUM_REQ-1:0]      r_gnt;
    logic [NUM_REQ-1:0]      w_gnt_nxt;
    logic [NUM_REQ-1:0]      w_win_onehot;
    logic [REQ_ID_WID-1:0]   r_gnt_id;
    logic [REQ_ID_WID-1:0]   w_gnt_id_nxt;
    logic [REQ_ID_WID-1:0]   r_rr_ptr;
    logic [REQ_ID_WID-1:0]   w_rr_ptr_nxt;
    logic [REQ_ID_WID-1:0]   w_ptr_adv;
    logic [REQ_ID_WID-1:0]   w_arb_ptr;
    logic [REQ_ID_WID-1:0]   w_hi_win;
    logic [REQ_ID_WID-1:0]   w_lo_win;
    logic [REQ_ID_WID-1:0]   w_win;
    logic                    w_hi_found;
    logic                    w_any_req;
    logic                    w_timeout;

    if (TIMEOUT_CYC < 1 || (1 << REQ_ID_WID) < NUM_REQ) begin : g_param_chk
        $error("arb_block_lv2: TIMEOUT_CYC must be >= 1 and REQ_ID_WID must cover NUM_REQ");
    end

    // Pointer after the current winner; on back-to-back the new arbitration
    // must already see it so the finishing core drops to lowest priority.
    always_comb begin
        w_ptr_adv = (r_gnt_id == REQ_ID_WID'(NUM_REQ - 1)) ? '0 : r_gnt_id + 1'b1;
        w_arb_ptr = (r_state == ST_WAIT) ? w_ptr_adv : r_rr_ptr;
        w_any_req = |req_proc;
    end

    // Descending scan so the last hit is the lowest index: first the lowest
    // requester at or above the pointer, otherwise the lowest one below it.
    always_comb begin
        w_hi_win   = '0;
        w_lo_win   = '0;
        w_hi_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_proc[i]) begin
                if (i >= int'(w_arb_ptr)) begin
                    w_hi_win   = REQ_ID_WID'(i);
                    w_hi_found = 1'b1;
                end else begin
                    w_lo_win = REQ_ID_WID'(i);
                end
            end
        end
        w_win              = w_hi_found ? w_hi_win : w_lo_win;
        w_win_onehot       = '0;
        w_win_onehot[w_win] = 1'b1;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_gnt_id_nxt = r_gnt_id;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt = '0;
                if (w_any_req) begin
                    w_gnt_nxt    = w_win_onehot;
                    w_gnt_id_nxt = w_win;
                    w_state_nxt  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (l2_done) begin
                    w_rr_ptr_nxt = w_ptr_adv;
                    if (w_any_req) begin
                        w_gnt_nxt    = w_win_onehot;
                        w_gnt_id_nxt = w_win;
                        w_state_nxt  = ST_ISSUE;
                    end else begin
                        w_gnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_timeout) begin
                    w_rr_ptr_nxt = w_ptr_adv;
                    w_gnt_nxt    = '0;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_timeout_err;

    // Counter is 0 in the first WAIT cycle; expiry lands on WAIT cycle TIMEOUT_CYC.
    always_comb begin
        w_timeout = (r_state == ST_WAIT) && !l2_done &&
                    (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == ST_WAIT && !l2_done && !w_timeout) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign gnt_proc = r_gnt;
    assign gnt_id   = r_gnt_id;
    assign l2_start = (r_state == ST_ISSUE);
    assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_arb_block_lv2.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb_block_lv2
// Brief    : Directed self-checking bench for arb_block_lv2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arb_block_lv2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_proc;
    logic       l2_done;
    logic [3:0] gnt_proc;
    logic [1:0] gnt_id;
    logic       l2_start;
    logic       busy;
    logic       timeout_err;

    int n_pass  = 0;
    int n_total = 0;

    arb_block_lv2 #(
        .NUM_REQ     (4),
        .REQ_ID_WID  (2),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_proc    (req_proc),
        .l2_done     (l2_done),
        .gnt_proc    (gnt_proc),
        .gnt_id      (gnt_id),
        .l2_start    (l2_start),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_proc = 4'b0000; l2_done = 1'b0;
        tick(); tick();
        rst = 1'b0;
        n_total++; if (gnt_proc !== 4'b0000) $display("FAIL reset_gnt: got %b expected %b", gnt_proc, 4'b0000); else n_pass++;
        n_total++; if (gnt_id !== 2'd0) $display("FAIL reset_id: got %0d expected 0", gnt_id); else n_pass++;
        n_total++; if (l2_start !== 1'b0) $display("FAIL reset_start: got %b expected 0", l2_start); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (timeout_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", timeout_err); else n_pass++;
        tick();
        n_total++; if (gnt_proc !== 4'b0000) $display("FAIL idle_no_req: got %b expected %b", gnt_proc, 4'b0000); else n_pass++;
    endtask

    task automatic test_single();
        req_proc = 4'b0100;
        tick();
        n_total++; if (gnt_proc !== 4'b0100) $display("FAIL single_gnt: got %b expected %b", gnt_proc, 4'b0100); else n_pass++;
        n_total++; if (gnt_id !== 2'd2) $display("FAIL single_id: got %0d expected 2", gnt_id); else n_pass++;
        n_total++; if (l2_start !== 1'b1) $display("FAIL single_start: got %b expected 1", l2_start); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL single_busy: got %b expected 1", busy); else n_pass++;
        req_proc = 4'b0000;
        tick();
        n_total++; if (l2_start !== 1'b0) $display("FAIL single_start_once: got %b expected 0", l2_start); else n_pass++;
        n_total++; if (gnt_proc !== 4'b0100) $display("FAIL single_hold: got %b expected %b", gnt_proc, 4'b0100); else n_pass++;
        tick(); tick();
        l2_done = 1'b1;
        tick();
        l2_done = 1'b0;
        n_total++; if (gnt_proc !== 4'b0000) $display("FAIL single_release: got %b expected %b", gnt_proc, 4'b0000); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL single_idle: got %b expected 0", busy); else n_pass++;
    endtask

    // Pointer is 3 after core 2 finished: 0011 must grant core 0, then core 1.
    task automatic test_wrap_skip();
        req_proc = 4'b0011;
        tick();
        n_total++; if (gnt_proc !== 4'b0001) $display("FAIL wrap_first: got %b expected %b", gnt_proc, 4'b0001); else n_pass++;
        tick();
        l2_done = 1'b1;
        tick();
        l2_done = 1'b0;
        n_total++; if (gnt_proc !== 4'b0010) $display("FAIL wrap_second: got %b expected %b", gnt_proc, 4'b0010); else n_pass++;
        n_total++; if (gnt_id !== 2'd1) $display("FAIL wrap_second_id: got %0d expected 1", gnt_id); else n_pass++;
        n_total++; if (l2_start !== 1'b1) $display("FAIL wrap_b2b_start: got %b expected 1", l2_start); else n_pass++;
        req_proc = 4'b0000;
        tick();
        l2_done = 1'b1;
        tick();
        l2_done = 1'b0;
        n_total++; if (gnt_proc !== 4'b0000) $display("FAIL wrap_release: got %b expected %b", gnt_proc, 4'b0000); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_id [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        rst = 1'b1; tick(); rst = 1'b0;
        req_proc = 4'b1111;
        tick();
        n_total++; if (gnt_proc !== 4'b0001) $display("FAIL rr_first: got %b expected %b", gnt_proc, 4'b0001); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_total++; if (busy !== 1'b1 || l2_start !== 1'b0) $display("FAIL rr_wait_%0d: got busy=%b start=%b expected busy=1 start=0", k, busy, l2_start); else n_pass++;
            l2_done = 1'b1;
            tick();
            l2_done = 1'b0;
            n_total++; if (gnt_id !== exp_id[k] || gnt_proc !== (4'b0001 << exp_id[k]) || l2_start !== 1'b1)
                $display("FAIL rr_grant_%0d: got id=%0d gnt=%b start=%b expected id=%0d start=1", k, gnt_id, gnt_proc, l2_start, exp_id[k]);
            else n_pass++;
        end
        req_proc = 4'b0000;
        tick();
        l2_done = 1'b1;
        tick();
        l2_done = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL rr_release: got busy=%b expected 0", busy); else n_pass++;
    endtask

    // Pointer is 1 here; done in ISSUE must be ignored and req changes must not move the grant.
    task automatic test_done_in_issue();
        req_proc = 4'b0001;
        tick();
        n_total++; if (gnt_proc !== 4'b0001) $display("FAIL issue_gnt: got %b expected %b", gnt_proc, 4'b0001); else n_pass++;
        l2_done = 1'b1;
        req_proc = 4'b1111;
        tick();
        l2_done = 1'b0;
        n_total++; if (gnt_proc !== 4'b0001 || busy !== 1'b1 || l2_start !== 1'b0)
            $display("FAIL issue_done_ignored: got gnt=%b busy=%b start=%b expected gnt=0001 busy=1 start=0", gnt_proc, busy, l2_start);
        else n_pass++;
        tick();
        n_total++; if (gnt_proc !== 4'b0001) $display("FAIL wait_hold: got %b expected %b", gnt_proc, 4'b0001); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++; if (gnt_proc !== 4'b0000 || busy !== 1'b0 || l2_start !== 1'b0)
            $display("FAIL rst_wait: got gnt=%b busy=%b start=%b expected 0000/0/0", gnt_proc, busy, l2_start);
        else n_pass++;
        l2_done = 1'b1;
        req_proc = 4'b0000;
        tick();
        l2_done = 1'b0;
        n_total++; if (gnt_proc !== 4'b0000 || busy !== 1'b0 || l2_start !== 1'b0)
            $display("FAIL rst_late_done: got gnt=%b busy=%b start=%b expected 0000/0/0", gnt_proc, busy, l2_start);
        else n_pass++;
        // 1001 grants core 0 only if the pointer was cleared (stale pointer 1 would pick core 3).
        req_proc = 4'b1001;
        tick();
        n_total++; if (gnt_proc !== 4'b0001) $display("FAIL rst_ptr_zero: got %b expected %b", gnt_proc, 4'b0001); else n_pass++;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        req_proc = 4'b0000;
        tick();
        repeat (7) tick();
        l2_done = 1'b1;
        tick();
        l2_done = 1'b0;
        n_total++; if (timeout_err !== 1'b0 || gnt_proc !== 4'b0000)
            $display("FAIL done_beats_timeout: got err=%b gnt=%b expected err=0 gnt=0000", timeout_err, gnt_proc);
        else n_pass++;
        req_proc = 4'b0100;
        tick();
        req_proc = 4'b0000;
        tick();
        repeat (7) tick();
        n_total++; if (gnt_proc !== 4'b0100 || timeout_err !== 1'b0)
            $display("FAIL timeout_wait8: got gnt=%b err=%b expected gnt=0100 err=0", gnt_proc, timeout_err);
        else n_pass++;
        tick();
        n_total++; if (timeout_err !== 1'b1 || gnt_proc !== 4'b0000 || busy !== 1'b0)
            $display("FAIL timeout_fire: got err=%b gnt=%b busy=%b expected 1/0000/0", timeout_err, gnt_proc, busy);
        else n_pass++;
        repeat (3) tick();
        n_total++; if (timeout_err !== 1'b1) $display("FAIL timeout_sticky: got %b expected 1", timeout_err); else n_pass++;
        req_proc = 4'b1111;
        tick();
        n_total++; if (gnt_proc !== 4'b1000) $display("FAIL timeout_ptr_adv: got %b expected %b", gnt_proc, 4'b1000); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_proc = 4'b0000;
        n_total++; if (timeout_err !== 1'b0) $display("FAIL timeout_rst_clear: got %b expected 0", timeout_err); else n_pass++;
    endtask
`else
    task automatic test_timeout();
        req_proc = 4'b0000;
        tick();
        repeat (20) tick();
        n_total++; if (gnt_proc !== 4'b0001 || busy !== 1'b1 || timeout_err !== 1'b0)
            $display("FAIL no_timeout_hold: got gnt=%b busy=%b err=%b expected 0001/1/0", gnt_proc, busy, timeout_err);
        else n_pass++;
        l2_done = 1'b1;
        tick();
        l2_done = 1'b0;
        n_total++; if (gnt_proc !== 4'b0000) $display("FAIL no_timeout_release: got %b expected %b", gnt_proc, 4'b0000); else n_pass++;
    endtask
`endif

    initial begin
        rst      = 1'b1;
        req_proc = 4'b0000;
        l2_done  = 1'b0;
        test_reset();
        test_single();
        test_wrap_skip();
        test_round_robin();
        test_done_in_issue();
        test_reset_mid_wait();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
